mc_controller: RTL and testbench
================================

# mc_controller

Multicycle main control unit for the MIPS datapath. A Moore state machine sequences each instruction through Fetch, Decode and the per-class execute, memory and writeback steps. It drives every datapath enable and mux select from the registered state and the instruction's Op and Funct fields. It sits directly upstream of the datapath and is its only source of control signals.

## Interface
Parameters:
- none; all encodings are fixed constants in mc_pkg.

Ports:
- clk  in  1  — single clock; all state changes on its rising edge.
- rst  in  1  — reset, synchronous and active-high.
- Op  in  6  — instr[31:26] from the datapath instruction register.
- Funct  in  6  — instr[5:0]; used only for R-type.
- PCWrite  out  1  — unconditional PC update.
- Branch  out  1  — conditional PC update; the datapath ANDs it with Zero.
- PCSrc  out  2  — next-PC select: 00 ALUResult, 01 ALUOut, 10 jump target {PC[31:28], instr[25:0], 2'b00}.
- ALUControl  out  3  — ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- ALUSrcA  out  1  — ALU A input: 0 PC, 1 A register.
- ALUSrcB  out  2  — ALU B input: 00 B, 01 constant 4, 10 sign-extended immediate, 11 sign-extended immediate << 2.
- lorD  out  1  — memory address select: 0 PC, 1 ALUOut.
- MemWrite  out  1  — memory write enable.
- IRWrite  out  1  — instruction register load.
- RegDst  out  1  — write register select: 0 rt, 1 rd.
- MemtoReg  out  1  — register write data select: 0 ALUOut, 1 Data.
- RegWrite  out  1  — register file write enable.
- illegal  out  1  — one-cycle pulse in Decode when Op is unsupported.
- state  out  4  — current state, for debug.

## Operation
- Supported instructions: lw 100011, sw 101011, R-type 000000, beq 000100, addi 001000, j 000010.
- Supported R-type Funct values: add 100000, sub 100010, and 100100, or 100101, slt 101010.
- States and their asserted outputs (any output not listed is 0 or don't-care):
  - FETCH: IRWrite=1, lorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=add, PCSrc=00, PCWrite=1.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUControl=add (computes the branch target into ALUOut).
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUControl=add.
  - MEMRD: lorD=1.
  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1.
  - MEMWR: lorD=1, MemWrite=1.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUControl=decoded from Funct.
  - ALUWB: RegDst=1, MemtoReg=0, RegWrite=1.
  - BEQ: ALUSrcA=1, ALUSrcB=00, ALUControl=sub, PCSrc=01, Branch=1.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUControl=add.
  - ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1.
  - JUMP: PCSrc=10, PCWrite=1.
- Transitions:
  - FETCH→DECODE.
  - DECODE→MEMADR for lw/sw, EXEC for R-type, BEQ for beq, ADDIEX for addi, JUMP for j. Any other Op goes to FETCH with illegal=1.
  - MEMADR→MEMRD for lw, MEMWR for sw.
  - MEMRD→MEMWB.
  - EXEC→ALUWB.
  - ADDIEX→ADDIWB.
  - MEMWB, MEMWR, ALUWB, BEQ, ADDIWB and JUMP all go to FETCH.
- An unsupported Funct in EXEC produces ALUControl=010 (add). The FSM flow is unaffected.
- Op is sampled only in DECODE and MEMADR. The instruction register is stable from DECODE onward.

## Timing
- Moore outputs: all outputs are a combinational decode of the registered state, so there are no Op→output paths. The exceptions are EXEC's ALUControl (depends on Funct) and illegal (depends on Op).
- Reset behaviour:
  - rst high at a rising edge puts state in FETCH.
  - While rst is high, PCWrite, Branch, IRWrite, MemWrite, RegWrite and illegal are forced to 0. The remaining outputs show FETCH values.
  - The first cycle after rst falls is a full FETCH.
- Reset mid-instruction abandons the instruction; no writeback or memory write occurs in the reset cycle.
- Latency in cycles, FETCH through the last state: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- Exactly one cycle asserts IRWrite per instruction. At most one cycle asserts RegWrite or MemWrite per instruction.
- The state encoding is 4-bit binary; unused codes go to FETCH on the next edge.

## Structure
- mc_pkg holds:
  - the state enum (4-bit);
  - opcode constants OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J;
  - Funct constants;
  - ALU codes ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT;
  - the ALUSrcB and PCSrc select encodings.
- Sub-module mc_alu_decoder (combinational) maps {ALUOp[1:0], Funct} to ALUControl. ALUOp comes from the state: 00 add, 01 sub, 10 Funct-decoded.
- Top level holds the state register, next-state logic and output decode.

## Test plan
- Reset then lw (Op=100011): rst held 2 cycles, then the state sequence is FETCH, DECODE, MEMADR, MEMRD, MEMWB. Cycle 5 has RegWrite=1, MemtoReg=1, RegDst=0; cycle 6 is FETCH.
- sw (Op=101011): in cycle 4 MemWrite=1 and lorD=1, RegWrite stays 0 throughout, and cycle 5 is FETCH.
- R-type sweep: Funct 100000/100010/100100/100101/101010 gives ALUControl 010/110/000/001/111 in EXEC. Cycle 4 has RegWrite=1, RegDst=1.
- beq and j:
  - beq: cycle 3 has Branch=1, PCSrc=01, ALUControl=110, PCWrite=0.
  - j: cycle 3 has PCWrite=1, PCSrc=10.
  - Both return to FETCH in cycle 4.
- Illegal Op=111111: illegal=1 in DECODE only, the next state is FETCH, and no write enable is asserted.
- rst asserted during MEMRD of an lw: the next state is FETCH, MEMWB is never entered, and RegWrite stays 0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS main control unit: FSM states,
// instruction fields, ALU operation codes and datapath mux selects.
package mc_pkg;

  // 4-bit binary state encoding; codes 12..15 are unused and recover to FETCH.
  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  // Opcodes (instr[31:26]).
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes (instr[5:0]).
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // ALU operation codes seen by the datapath ALU.
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Coarse ALU request from the FSM; the decoder refines FUNCT via Funct.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_e;

  // ALU B-input select.
  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // Next-PC select.
  localparam logic [1:0] PCSRC_ALURESULT = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT    = 2'b01;
  localparam logic [1:0] PCSRC_JUMP      = 2'b10;

  // True for every opcode the control unit knows how to sequence.
  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// ALU decoder: turns the FSM's coarse ALU request plus the R-type Funct field
// into the 3-bit ALU operation code. Purely combinational.
module mc_alu_decoder
  import mc_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_control_o
);

  // Map ALUOp/Funct to the ALU operation; anything unrecognised falls back to add.
  always_comb begin
    // NOTE: defaulting the output before the case keeps every path assigned, so no latch is inferred.
    alu_control_o = ALU_ADD;
    unique case (alu_op_i)
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          FUNCT_ADD: alu_control_o = ALU_ADD;
          FUNCT_SUB: alu_control_o = ALU_SUB;
          FUNCT_AND: alu_control_o = ALU_AND;
          FUNCT_OR:  alu_control_o = ALU_OR;
          FUNCT_SLT: alu_control_o = ALU_SLT;
          default:   alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS main control unit. A Moore FSM steps each instruction through
// FETCH, DECODE and its class-specific execute/memory/writeback states and
// drives every datapath enable and mux select from the registered state.
module mc_controller
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  output logic       PCWrite,
  output logic       Branch,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUControl,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       lorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       illegal,
  output logic [3:0] state
);

  state_e state_q;
  state_e state_d;
  state_e state_eff;
  aluop_e alu_op;

  // While reset is held the outputs present FETCH regardless of the register,
  // so the datapath sees FETCH mux selects from the very first reset cycle.
  assign state_eff = rst ? S_FETCH : state_q;
  assign state     = state_eff;

  // State register with synchronous reset into FETCH.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state logic; Op is only consulted in DECODE and MEMADR.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_ALUWB;
      S_ADDIEX: state_d = S_ADDIWB;
      // Writeback, store, branch and jump states, plus unused codes, restart at FETCH.
      default:  state_d = S_FETCH;
    endcase
  end

  // Output decode from the effective state; write enables are killed during reset.
  always_comb begin
    PCWrite  = 1'b0;
    Branch   = 1'b0;
    PCSrc    = PCSRC_ALURESULT;
    alu_op   = ALUOP_ADD;
    ALUSrcA  = 1'b0;
    ALUSrcB  = SRCB_B;
    lorD     = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    illegal  = 1'b0;
    case (state_eff)
      S_FETCH: begin
        IRWrite = 1'b1;
        ALUSrcB = SRCB_FOUR;
        PCWrite = 1'b1;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMM_SH2;
        illegal = !op_supported(Op);
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: lorD = 1'b1;
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        lorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        alu_op  = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = 1'b1;
        alu_op  = ALUOP_SUB;
        PCSrc   = PCSRC_ALUOUT;
        Branch  = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_ADDIWB: RegWrite = 1'b1;
      S_JUMP: begin
        PCSrc   = PCSRC_JUMP;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      PCWrite  = 1'b0;
      Branch   = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      illegal  = 1'b0;
    end
  end

  mc_alu_decoder u_alu_decoder (
    .alu_op_i      (alu_op),
    .funct_i       (Funct),
    .alu_control_o (ALUControl)
  );

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: a driver issues directed and random
// instructions and queues the expected per-cycle outputs from a table model;
// a monitor on the falling edge pops and compares.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] Op, Funct;
  logic       PCWrite, Branch, ALUSrcA, lorD, MemWrite, IRWrite;
  logic       RegDst, MemtoReg, RegWrite, illegal;
  logic [1:0] PCSrc, ALUSrcB;
  logic [2:0] ALUControl;
  logic [3:0] state;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct),
    .PCWrite(PCWrite), .Branch(Branch), .PCSrc(PCSrc), .ALUControl(ALUControl),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .lorD(lorD), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .illegal(illegal), .state(state)
  );

  // Debug state codes as exposed on the state port.
  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4,
                 S_MEMWR = 5, S_EXEC = 6, S_ALUWB = 7, S_BEQ = 8, S_ADDIEX = 9,
                 S_ADDIWB = 10, S_JUMP = 11;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic [1:0] pcsrc;
    logic [2:0] aluctl;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       lord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       illegal;
    logic [3:0] st;
  } outs_t;

  typedef struct {
    outs_t val;
    outs_t care;
    string name;
  } exp_t;

  exp_t  sb_q[$];
  int    total = 0;
  int    bad   = 0;
  outs_t act;

  assign act = {PCWrite, Branch, PCSrc, ALUControl, ALUSrcA, ALUSrcB, lorD,
                MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, illegal, state};

  task automatic check(input string name, input outs_t a, input outs_t v, input outs_t c);
    total++;
    if (((a ^ v) & c) !== '0) begin
      bad++;
      $display("FAIL %s: got %h want %h (care mask %h)", name, a, v, c);
    end
  endtask

  function automatic logic legal_op(input logic [5:0] op);
    return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected outputs for one cycle in state s, straight from the state table.
  // Write enables and illegal are always checked; selects only where listed.
  function automatic exp_t model(input int s, input logic [5:0] op, input logic [5:0] fn,
                                 input string nm);
    exp_t e;
    e.val  = '0;
    e.care = '0;
    e.name = nm;
    e.care.pcwrite = 1'b1; e.care.branch = 1'b1; e.care.memwrite = 1'b1;
    e.care.irwrite = 1'b1; e.care.regwrite = 1'b1; e.care.illegal = 1'b1;
    e.care.st = '1;
    e.val.st = 4'(s);
    case (s)
      S_FETCH: begin
        e.val.irwrite = 1'b1; e.val.pcwrite = 1'b1;
        e.val.lord = 1'b0;       e.care.lord = 1'b1;
        e.val.alusrca = 1'b0;    e.care.alusrca = 1'b1;
        e.val.alusrcb = 2'b01;   e.care.alusrcb = '1;
        e.val.aluctl = 3'b010;   e.care.aluctl = '1;
        e.val.pcsrc = 2'b00;     e.care.pcsrc = '1;
      end
      S_DECODE: begin
        e.val.alusrca = 1'b0;    e.care.alusrca = 1'b1;
        e.val.alusrcb = 2'b11;   e.care.alusrcb = '1;
        e.val.aluctl = 3'b010;   e.care.aluctl = '1;
        e.val.illegal = !legal_op(op);
      end
      S_MEMADR, S_ADDIEX: begin
        e.val.alusrca = 1'b1;    e.care.alusrca = 1'b1;
        e.val.alusrcb = 2'b10;   e.care.alusrcb = '1;
        e.val.aluctl = 3'b010;   e.care.aluctl = '1;
      end
      S_MEMRD: begin
        e.val.lord = 1'b1;       e.care.lord = 1'b1;
      end
      S_MEMWB: begin
        e.val.regwrite = 1'b1;
        e.val.regdst = 1'b0;     e.care.regdst = 1'b1;
        e.val.memtoreg = 1'b1;   e.care.memtoreg = 1'b1;
      end
      S_MEMWR: begin
        e.val.memwrite = 1'b1;
        e.val.lord = 1'b1;       e.care.lord = 1'b1;
      end
      S_EXEC: begin
        e.val.alusrca = 1'b1;    e.care.alusrca = 1'b1;
        e.val.alusrcb = 2'b00;   e.care.alusrcb = '1;
        e.val.aluctl = funct_alu(fn); e.care.aluctl = '1;
      end
      S_ALUWB: begin
        e.val.regwrite = 1'b1;
        e.val.regdst = 1'b1;     e.care.regdst = 1'b1;
        e.val.memtoreg = 1'b0;   e.care.memtoreg = 1'b1;
      end
      S_BEQ: begin
        e.val.branch = 1'b1;
        e.val.alusrca = 1'b1;    e.care.alusrca = 1'b1;
        e.val.alusrcb = 2'b00;   e.care.alusrcb = '1;
        e.val.aluctl = 3'b110;   e.care.aluctl = '1;
        e.val.pcsrc = 2'b01;     e.care.pcsrc = '1;
      end
      S_ADDIWB: begin
        e.val.regwrite = 1'b1;
        e.val.regdst = 1'b0;     e.care.regdst = 1'b1;
        e.val.memtoreg = 1'b0;   e.care.memtoreg = 1'b1;
      end
      S_JUMP: begin
        e.val.pcwrite = 1'b1;
        e.val.pcsrc = 2'b10;     e.care.pcsrc = '1;
      end
      default: ;
    endcase
    return e;
  endfunction

  // Reset cycle: FETCH selects, every enable and illegal low.
  function automatic exp_t reset_exp(input string nm);
    exp_t e;
    e = model(S_FETCH, 6'b0, 6'b0, nm);
    e.val.pcwrite = 1'b0;
    e.val.irwrite = 1'b0;
    return e;
  endfunction

  // Drive one instruction; if rst_at names a cycle inside it, reset is asserted
  // there and the instruction is abandoned.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int rst_at);
    int seq[$];
    seq = {S_FETCH, S_DECODE};
    case (op)
      6'b100011: seq = {seq, S_MEMADR, S_MEMRD, S_MEMWB};
      6'b101011: seq = {seq, S_MEMADR, S_MEMWR};
      6'b000000: seq = {seq, S_EXEC, S_ALUWB};
      6'b000100: seq = {seq, S_BEQ};
      6'b001000: seq = {seq, S_ADDIEX, S_ADDIWB};
      6'b000010: seq = {seq, S_JUMP};
      default: ;
    endcase
    Op    = op;
    Funct = fn;
    for (int k = 0; k < seq.size(); k++) begin
      if (k == rst_at) begin
        rst = 1'b1;
        sb_q.push_back(reset_exp($sformatf("op%b_rst_c%0d", op, k + 1)));
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      sb_q.push_back(model(seq[k], op, fn, $sformatf("op%b_fn%b_c%0d", op, fn, k + 1)));
      @(posedge clk); #1;
    end
  endtask

  // Monitor: compare on the falling edge, away from the state update.
  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check(e.name, act, e.val, e.care);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  logic [5:0] ops[7];
  logic [5:0] fns[5];

  initial begin
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b111111};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    rst   = 1'b1;
    Op    = 6'b0;
    Funct = 6'b0;
    @(posedge clk); #1;
    repeat (2) begin
      sb_q.push_back(reset_exp("reset"));
      @(posedge clk); #1;
    end
    rst = 1'b0;

    // Directed: lw, sw, R-type sweep plus an unknown Funct, beq, j, illegal.
    run_instr(6'b100011, 6'b0, -1);
    run_instr(6'b101011, 6'b0, -1);
    for (int i = 0; i < 5; i++) run_instr(6'b000000, fns[i], -1);
    run_instr(6'b000000, 6'b111111, -1);
    run_instr(6'b001000, 6'b0, -1);
    run_instr(6'b000100, 6'b0, -1);
    run_instr(6'b000010, 6'b0, -1);
    run_instr(6'b111111, 6'b0, -1);
    // Reset during MEMRD (fourth cycle) of an lw, then a clean lw.
    run_instr(6'b100011, 6'b0, 3);
    run_instr(6'b100011, 6'b0, -1);

    // Random instruction stream with occasional mid-instruction resets.
    for (int n = 0; n < 200; n++) begin
      logic [5:0] op, fn;
      int         ra;
      op = ops[$urandom_range(0, 6)];
      if (op == 6'b111111) op = 6'($urandom);
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
      ra = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr(op, fn, ra);
    end

    repeat (2) @(negedge clk);
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
